// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared definitions for the shared shift-add multiplier
// scheduler.
//
// Contents:
//   DEF_WIDTH  default operand width in bits (product is 2*DEF_WIDTH bits)
//   DEF_CNT_W  default bit-counter width; 2**DEF_CNT_W must exceed DEF_WIDTH
//   state_t    scheduler FSM encoding (S_IDLE, S_RUN, S_DONE)
package mult_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : mult_sched_pkg

// File: rtl/mult_sched_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//
// Ports:
//   req0, req1  input   request levels from port 0 and port 1
//   last        input   index of the most recently granted port
//   any         output  at least one port is requesting
//   winner      output  index of the chosen port (valid when any=1)
//
// A lone requester always wins. When both request, the port that was not
// served last wins, so a continuously requesting port cannot starve the
// other one.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic winner
);

  assign any = req0 | req1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule : rr_arb2

// File: rtl/mult_sched.sv
// mult_sched: shares one sequential shift-add multiplier between two
// requesters using round-robin arbitration.
//
// Parameters:
//   WIDTH   operand width in bits; products are 2*WIDTH bits
//   CNT_W   bit-counter width; 2**CNT_W must exceed WIDTH
//
// Ports:
//   topclock           input   single clock, rising-edge active
//   topreset           input   synchronous active-high reset
//   req0, a0, b0       input   port 0 request level and operands
//   req1, a1, b1       input   port 1 request level and operands
//   busy               output  operation in progress (state != IDLE)
//   gnt                output  index of the current or last granted port
//   done0, result0     output  port 0 one-cycle done pulse and held product
//   done1, result1     output  port 1 one-cycle done pulse and held product
//
// Build option:
//   MULT_SCHED_ZERO_SKIP_EN  when defined, a grant whose multiplicand or
//   multiplier is zero goes straight to DONE with a zero product (done
//   visible one cycle after the grant edge). When undefined, zero operands
//   run the full WIDTH cycles like any other operands.
//
// Operation: in IDLE the arbiter picks a requester, whose operands are
// latched. RUN then processes one multiplier bit per clock: the
// multiplicand is kept pre-shifted so that on every edge it equals
// opa << cnt, and the multiplier is shifted right so its LSB is opb[cnt].
// The edge that consumes the last bit writes the product and done flag of
// the granted port, so both are visible during the single DONE cycle.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               topclock,
  input  logic               topreset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               busy,
  output logic               gnt,
  output logic               done0,
  output logic [2*WIDTH-1:0] result0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result1
);

  localparam int PW = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;

  logic             any;
  logic             winner;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             zero_op;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  // Arbitration is only acted on in IDLE; gnt doubles as the "last served"
  // history, and resets to 1 so port 0 wins the first contention.
  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .last   (gnt),
    .any    (any),
    .winner (winner)
  );

  assign win_a    = winner ? a1 : a0;
  assign win_b    = winner ? b1 : b0;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state != S_IDLE);

`ifdef MULT_SCHED_ZERO_SKIP_EN
  assign zero_op = (win_a == '0) || (win_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Conditional add of the pre-shifted multiplicand for the current bit.
  // The largest product (2**WIDTH-1)**2 fits in PW bits, so no carry out.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge topclock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (topreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (any) begin
          state_nxt = zero_op ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath, grant register and per-port result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge topclock) begin
    if (topreset) begin
      gnt     <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result0 <= '0;
      result1 <= '0;
    end else begin
      // Done flags are single-cycle pulses; only the completing edge sets one.
      done0 <= 1'b0;
      done1 <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (any) begin
            gnt    <= winner;
            mcand  <= {{WIDTH{1'b0}}, win_a};
            mplier <= win_b;
            acc    <= '0;
            cnt    <= '0;
            // Zero-skip completes on the grant edge itself; only the
            // winner's result and done are written.
            if (zero_op) begin
              if (winner) begin
                result1 <= '0;
                done1   <= 1'b1;
              end else begin
                result0 <= '0;
                done0   <= 1'b1;
              end
            end
          end
        end

        S_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // The final add is folded straight into the result register so
          // the product is visible during DONE alongside the done pulse.
          if (last_bit) begin
            if (gnt) begin
              result1 <= acc_nxt;
              done1   <= 1'b1;
            end else begin
              result0 <= acc_nxt;
              done0   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Results hold; the done pulse has already been cleared above.
        end

        default: begin
        end
      endcase
    end
  end

endmodule : mult_sched

// File: tb/tb_mult_sched.sv
// tb_mult_sched: self-checking bench for mult_sched.
// Directed scenarios followed by randomized traffic; expected products,
// latencies and grant order come from a plain arithmetic/round-robin model.
module tb_mult_sched;

  localparam int W  = 4;
  localparam int PW = 2 * W;
`ifdef MULT_SCHED_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          topclock = 1'b0;
  logic          topreset;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          busy, gnt, done0, done1;
  logic [PW-1:0] result0, result1;

  int total = 0;
  int bad   = 0;

  // Reference model state: last served port and each port's held product.
  bit            model_last;
  logic [PW-1:0] model_res [2];

  mult_sched #(.WIDTH(W), .CNT_W(3)) dut (
    .topclock (topclock),
    .topreset (topreset),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .busy     (busy),
    .gnt      (gnt),
    .done0    (done0),
    .result0  (result0),
    .done1    (done1),
    .result1  (result1)
  );

  always #5 topclock = ~topclock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return PW'(p);
  endfunction

  // Cycles from the grant edge until done is visible.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (ZS && (a == '0 || b == '0)) return 1;
    return W + 1;
  endfunction

  function automatic logic [PW-1:0] res_of(input bit port);
    return port ? result1 : result0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit port, input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; end
  endtask

  task automatic drop(input bit port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic do_reset();
    topreset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge topclock); #1;
    @(posedge topclock); #1;
    topreset = 1'b0;
    model_last   = 1'b1;
    model_res[0] = '0;
    model_res[1] = '0;
  endtask

  // Steps cycle by cycle (sampling #1 after each edge) until `port` shows
  // done, bounded to 20 cycles. lat=0 means no done was seen. At cycle
  // corrupt_at the port's request is dropped and its operands scrambled.
  task automatic wait_done(input bit port, input int corrupt_at,
                           output int lat, output int busy_cnt,
                           output bit other_done, output bit gnt_at);
    lat = 0; busy_cnt = 0; other_done = 1'b0; gnt_at = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge topclock); #1;
      if (busy) busy_cnt++;
      if (n == corrupt_at) begin
        drop(port);
        if (port) begin a1 = W'($urandom); b1 = W'($urandom); end
        else      begin a0 = W'($urandom); b0 = W'($urandom); end
      end
      if (port ? done1 : done0) begin
        lat = n; gnt_at = gnt;
        break;
      end
      if (port ? done0 : done1) other_done = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd7;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt got=%0d want=1", gnt); end
    total++; if ({done0, done1} !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", {done0, done1}); end
    total++; if (result0 !== model_res[0]) begin bad++; $display("FAIL reset_result0 got=%0d want=%0d", result0, model_res[0]); end
    total++; if (result1 !== model_res[1]) begin bad++; $display("FAIL reset_result1 got=%0d want=%0d", result1, model_res[1]); end
  endtask

  task automatic test_single();
    int lat, bc; bit od, g;
    drive(0, 4'd11, 4'd13);
    wait_done(0, 0, lat, bc, od, g);
    drop(0);
    total++; if (lat !== exp_lat(4'd11, 4'd13)) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, exp_lat(4'd11, 4'd13)); end
    total++; if (result0 !== prod(4'd11, 4'd13)) begin bad++; $display("FAIL single_result0 got=%0d want=%0d", result0, prod(4'd11, 4'd13)); end
    total++; if (g !== 1'b0) begin bad++; $display("FAIL single_gnt got=%0d want=0", g); end
    total++; if (bc !== W + 1) begin bad++; $display("FAIL single_busy_cycles got=%0d want=%0d", bc, W + 1); end
    total++; if (od !== 1'b0) begin bad++; $display("FAIL single_other_done got=%0d want=0", od); end
    model_res[0] = prod(4'd11, 4'd13); model_last = 1'b0;
    @(posedge topclock); #1;
    total++; if ({busy, done0} !== 2'b00) begin bad++; $display("FAIL single_after busy/done got=%b want=00", {busy, done0}); end
    total++; if (result0 !== model_res[0]) begin bad++; $display("FAIL single_hold got=%0d want=%0d", result0, model_res[0]); end
  endtask

  task automatic test_both();
    int lat, bc; bit od, g;
    do_reset();
    drive(0, 4'd10, 4'd5);
    drive(1, 4'd1, 4'd15);
    wait_done(0, 0, lat, bc, od, g);
    drop(0);
    total++; if (lat !== exp_lat(4'd10, 4'd5)) begin bad++; $display("FAIL both_lat0 got=%0d want=%0d", lat, exp_lat(4'd10, 4'd5)); end
    total++; if (result0 !== prod(4'd10, 4'd5)) begin bad++; $display("FAIL both_result0 got=%0d want=%0d", result0, prod(4'd10, 4'd5)); end
    total++; if (result1 !== model_res[1]) begin bad++; $display("FAIL both_result1_untouched got=%0d want=%0d", result1, model_res[1]); end
    total++; if (od !== 1'b0) begin bad++; $display("FAIL both_other_done got=%0d want=0", od); end
    model_res[0] = prod(4'd10, 4'd5); model_last = 1'b0;
    wait_done(1, 0, lat, bc, od, g);
    drop(1);
    total++; if (lat !== 1 + exp_lat(4'd1, 4'd15)) begin bad++; $display("FAIL both_lat1 got=%0d want=%0d", lat, 1 + exp_lat(4'd1, 4'd15)); end
    total++; if (result1 !== prod(4'd1, 4'd15)) begin bad++; $display("FAIL both_result1 got=%0d want=%0d", result1, prod(4'd1, 4'd15)); end
    total++; if (g !== 1'b1) begin bad++; $display("FAIL both_gnt1 got=%0d want=1", g); end
    total++; if (result0 !== model_res[0]) begin bad++; $display("FAIL both_result0_hold got=%0d want=%0d", result0, model_res[0]); end
    model_res[1] = prod(4'd1, 4'd15); model_last = 1'b1;
    @(posedge topclock); #1;
  endtask

  task automatic test_alternate();
    int lat, bc; bit od, g;
    bit order [3];
    drive(0, 4'd15, 4'd1);
    drive(1, 4'd15, 4'd15);
    wait_done(0, 0, lat, bc, od, g); order[0] = g;
    total++; if (lat !== exp_lat(4'd15, 4'd1)) begin bad++; $display("FAIL alt_lat_a got=%0d want=%0d", lat, exp_lat(4'd15, 4'd1)); end
    wait_done(1, 0, lat, bc, od, g); order[1] = g;
    drop(1);
    total++; if (lat !== 1 + exp_lat(4'd15, 4'd15)) begin bad++; $display("FAIL alt_lat_b got=%0d want=%0d", lat, 1 + exp_lat(4'd15, 4'd15)); end
    wait_done(0, 0, lat, bc, od, g); order[2] = g;
    drop(0);
    total++; if (lat !== 1 + exp_lat(4'd15, 4'd1)) begin bad++; $display("FAIL alt_lat_c got=%0d want=%0d", lat, 1 + exp_lat(4'd15, 4'd1)); end
    total++; if ({order[0], order[1], order[2]} !== 3'b010) begin bad++; $display("FAIL alt_grant_order got=%b want=010", {order[0], order[1], order[2]}); end
    model_res[0] = prod(4'd15, 4'd1); model_res[1] = prod(4'd15, 4'd15); model_last = 1'b0;
    total++; if (result0 !== model_res[0]) begin bad++; $display("FAIL alt_result0 got=%0d want=%0d", result0, model_res[0]); end
    total++; if (result1 !== model_res[1]) begin bad++; $display("FAIL alt_result1 got=%0d want=%0d", result1, model_res[1]); end
    @(posedge topclock); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit od, g, seen;
    drive(0, 4'd11, 4'd13);
    @(posedge topclock); #1;   // grant edge, RUN cycle 1
    @(posedge topclock); #1;   // RUN cycle 2
    @(posedge topclock); #1;   // RUN cycle 3
    topreset = 1'b1;
    drop(0);
    @(posedge topclock); #1;
    topreset = 1'b0;
    model_res[0] = '0; model_res[1] = '0; model_last = 1'b1;
    total++; if ({busy, done0, done1} !== 3'b000) begin bad++; $display("FAIL midreset_flags got=%b want=000", {busy, done0, done1}); end
    total++; if (result0 !== model_res[0]) begin bad++; $display("FAIL midreset_result0 got=%0d want=%0d", result0, model_res[0]); end
    total++; if (result1 !== model_res[1]) begin bad++; $display("FAIL midreset_result1 got=%0d want=%0d", result1, model_res[1]); end
    total++; if (gnt !== model_last) begin bad++; $display("FAIL midreset_gnt got=%0d want=%0d", gnt, model_last); end
    seen = 1'b0;
    repeat (7) begin
      @(posedge topclock); #1;
      if (done0 || done1 || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_quiet got=%0d want=0", seen); end
    drive(0, 4'd11, 4'd13);
    wait_done(0, 0, lat, bc, od, g);
    drop(0);
    total++; if (lat !== exp_lat(4'd11, 4'd13)) begin bad++; $display("FAIL midreset_fresh_lat got=%0d want=%0d", lat, exp_lat(4'd11, 4'd13)); end
    total++; if (result0 !== prod(4'd11, 4'd13)) begin bad++; $display("FAIL midreset_fresh_result got=%0d want=%0d", result0, prod(4'd11, 4'd13)); end
    model_res[0] = prod(4'd11, 4'd13); model_last = 1'b0;
    @(posedge topclock); #1;
  endtask

  task automatic test_ignore_inputs();
    int lat, bc; bit od, g;
    drive(0, 4'd15, 4'd15);
    wait_done(0, 2, lat, bc, od, g);
    total++; if (lat !== exp_lat(4'd15, 4'd15)) begin bad++; $display("FAIL ignore_lat got=%0d want=%0d", lat, exp_lat(4'd15, 4'd15)); end
    total++; if (result0 !== prod(4'd15, 4'd15)) begin bad++; $display("FAIL ignore_result0 got=%0d want=%0d", result0, prod(4'd15, 4'd15)); end
    model_res[0] = prod(4'd15, 4'd15); model_last = 1'b0;
    @(posedge topclock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%0d want=0", busy); end
  endtask

  task automatic test_zero();
    int lat, bc; bit od, g;
    drive(0, 4'd0, 4'd15);
    wait_done(0, 0, lat, bc, od, g);
    drop(0);
    total++; if (lat !== exp_lat(4'd0, 4'd15)) begin bad++; $display("FAIL zero0_lat got=%0d want=%0d", lat, exp_lat(4'd0, 4'd15)); end
    total++; if (result0 !== prod(4'd0, 4'd15)) begin bad++; $display("FAIL zero0_result got=%0d want=%0d", result0, prod(4'd0, 4'd15)); end
    model_res[0] = '0; model_last = 1'b0;
    @(posedge topclock); #1;
    drive(1, 4'd15, 4'd0);
    wait_done(1, 0, lat, bc, od, g);
    drop(1);
    total++; if (lat !== exp_lat(4'd15, 4'd0)) begin bad++; $display("FAIL zero1_lat got=%0d want=%0d", lat, exp_lat(4'd15, 4'd0)); end
    total++; if (result1 !== prod(4'd15, 4'd0)) begin bad++; $display("FAIL zero1_result got=%0d want=%0d", result1, prod(4'd15, 4'd0)); end
    total++; if (g !== 1'b1) begin bad++; $display("FAIL zero1_gnt got=%0d want=1", g); end
    model_res[1] = '0; model_last = 1'b1;
    @(posedge topclock); #1;
  endtask

  task automatic test_random();
    int lat, bc, mode; bit od, g, w;
    logic [W-1:0] ra [2];
    logic [W-1:0] rb [2];
    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        ra[p] = W'($urandom);
        rb[p] = W'($urandom);
        if ($urandom_range(0, 7) == 0) ra[p] = '0;
      end
      if (mode == 2) begin
        drive(0, ra[0], rb[0]);
        drive(1, ra[1], rb[1]);
        w = ~model_last;
      end else begin
        w = (mode == 1);
        drive(w, ra[w], rb[w]);
      end
      wait_done(w, 0, lat, bc, od, g);
      drop(w);
      total++; if (lat !== exp_lat(ra[w], rb[w])) begin bad++; $display("FAIL rand%0d_lat port=%0d got=%0d want=%0d", it, w, lat, exp_lat(ra[w], rb[w])); end
      total++; if (res_of(w) !== prod(ra[w], rb[w])) begin bad++; $display("FAIL rand%0d_result port=%0d got=%0d want=%0d", it, w, res_of(w), prod(ra[w], rb[w])); end
      total++; if (g !== w) begin bad++; $display("FAIL rand%0d_gnt got=%0d want=%0d", it, g, w); end
      total++; if (res_of(!w) !== model_res[!w]) begin bad++; $display("FAIL rand%0d_other_hold got=%0d want=%0d", it, res_of(!w), model_res[!w]); end
      total++; if (od !== 1'b0) begin bad++; $display("FAIL rand%0d_other_done got=%0d want=0", it, od); end
      model_res[w] = prod(ra[w], rb[w]);
      model_last   = w;
      if (mode == 2) begin
        wait_done(!w, 0, lat, bc, od, g);
        drop(!w);
        total++; if (lat !== 1 + exp_lat(ra[!w], rb[!w])) begin bad++; $display("FAIL rand%0d_lat2 got=%0d want=%0d", it, lat, 1 + exp_lat(ra[!w], rb[!w])); end
        total++; if (res_of(!w) !== prod(ra[!w], rb[!w])) begin bad++; $display("FAIL rand%0d_result2 got=%0d want=%0d", it, res_of(!w), prod(ra[!w], rb[!w])); end
        model_res[!w] = prod(ra[!w], rb[!w]);
        model_last    = !w;
      end
      @(posedge topclock); #1;
    end
  endtask

  initial begin
    topreset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_reset_mid();
    test_ignore_inputs();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mult_sched
